// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and default receive FIFO depth.
package uart_pkg;

    localparam int unsigned UART_BYTE_W     = 8;
    localparam int unsigned UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with sticky overflow flag.
// Accepts a byte on a one-cycle strobe and hands it to the consumer via valid/ready.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_FIFO_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   CLK50M,
    input  logic                   RST,
    input  logic                   wr_stb,
    input  logic [UART_BYTE_W-1:0] wr_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [UART_BYTE_W-1:0] rd_data,
    output logic [ADDR_W:0]        count,
    output logic                   full,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    logic [UART_BYTE_W-1:0] mem [0:DEPTH-1];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              rd_accept;
    logic              wr_accept;
    logic              wr_drop;

    assign rd_valid = (count_q != '0);
    assign full     = (count_q == (ADDR_W + 1)'(DEPTH));
    assign rd_data  = mem[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

    assign rd_accept = rd_valid && rd_ready;
    // A read in the same cycle frees a slot, so a full FIFO can still take a byte.
    assign wr_accept = wr_stb && (!full || rd_accept);
    assign wr_drop   = wr_stb && !wr_accept;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (wr_accept && !rd_accept) begin
            count_d = count_q + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - 1'b1;
        end

        if (wr_drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge CLK50M) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK50M) begin
        if (!RST && wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule
